// File: rtl/muxn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : muxn_pipe
// Purpose  : Parametrised N-way word selector with a registered output,
//            valid/ready handshake and a 2-entry (main + skid) buffer.
//            Out-of-range selects yield an all-zero word and set a sticky
//            error flag.
// Revision : 1.0 - initial release
// ============================================================================
module muxn_pipe #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN*DATA_W-1:0] data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        data_out,
    output logic                     sel_err
);

    // Unpacked view of the input words
    logic [DATA_W-1:0] w_words [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign w_words[gi] = data_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Selected word and whether sel named an existing input
    logic [DATA_W-1:0] w_sel_word;
    logic              w_sel_ok;

    // State: main entry drives the output, skid entry absorbs one word of
    // back-pressure so in_ready can be a pure register.
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              sel_err_q, sel_err_d;

    logic w_push;
    logic w_pop;

    // Decode sel into a word; anything beyond NUM_IN-1 selects zero
    always_comb begin
        w_sel_word = '0;
        w_sel_ok   = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(sel) == 32'(i)) begin
                w_sel_word = w_words[i];
                w_sel_ok   = 1'b1;
            end
        end
    end

    assign w_push = in_valid & in_ready_q;
    assign w_pop  = main_valid_q & out_ready;

    // Next-state for the main/skid pair, ready and the sticky error
    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        sel_err_d    = sel_err_q | (w_push & ~w_sel_ok);

        if (flush) begin
            // Buffered words and any word arriving now are dropped
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_pop && skid_valid_q) begin
            // in_ready is low here, so no push can coincide
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (w_pop) begin
            main_valid_d = w_push;
            if (w_push) begin
                main_data_d = w_sel_word;
            end
        end else if (!main_valid_q) begin
            if (w_push) begin
                main_data_d  = w_sel_word;
                main_valid_d = 1'b1;
            end
        end else begin
            if (w_push) begin
                skid_data_d  = w_sel_word;
                skid_valid_d = 1'b1;
            end
        end

        in_ready_d = ~skid_valid_d;
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            sel_err_q    <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign data_out  = main_data_q;
    assign out_valid = main_valid_q;
    assign in_ready  = in_ready_q;
    assign sel_err   = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_muxn_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_muxn_pipe
// Purpose  : Directed checks of muxn_pipe (default parameters) followed by a
//            random valid/ready run on an 8-bit, 5-input instance against a
//            reference queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muxn_pipe;

    localparam logic [31:0] C_A = 32'h11111111;
    localparam logic [31:0] C_B = 32'h22222222;
    localparam logic [31:0] C_C = 32'h33333333;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [95:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        sel_err;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [2:0]  s_sel;
    logic [39:0] s_data_in;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_data_out;
    logic        s_sel_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muxn_pipe #(.DATA_W(32), .NUM_IN(3), .SEL_W(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .sel_err   (sel_err)
    );

    muxn_pipe #(.DATA_W(8), .NUM_IN(5), .SEL_W(3)) u_dut_sweep (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .sel       (s_sel),
        .data_in   (s_data_in),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .data_out  (s_data_out),
        .sel_err   (s_sel_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set before the call are sampled at the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_w;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = 2'd0; data_in = {C_C, C_B, C_A};
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_sel = 3'd0; s_data_in = '0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Stream with out_ready high
        out_ready = 1'b1; in_valid = 1'b1; sel = 2'd0;
        tick();
        chk("stream_v0", 32'(out_valid), 32'd1);
        chk("stream_d0", data_out, C_A);
        chk("stream_rdy0", 32'(in_ready), 32'd1);
        sel = 2'd1;
        tick();
        chk("stream_d1", data_out, C_B);
        chk("stream_rdy1", 32'(in_ready), 32'd1);
        sel = 2'd2;
        tick();
        chk("stream_d2", data_out, C_C);
        in_valid = 1'b0;
        tick();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // Back-pressure into the skid entry
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
        tick();
        chk("bp_v", 32'(out_valid), 32'd1);
        chk("bp_d", data_out, C_B);
        chk("bp_rdy", 32'(in_ready), 32'd1);
        sel = 2'd2;
        tick();
        chk("bp_hold_d", data_out, C_B);
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("bp_hold2_d", data_out, C_B);
        chk("bp_hold2_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_v", 32'(out_valid), 32'd1);
        chk("bp_rel_d", data_out, C_C);
        chk("bp_rel_rdy", 32'(in_ready), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Out-of-range select
        in_valid = 1'b1; sel = 2'd3;
        tick();
        chk("oor_v", 32'(out_valid), 32'd1);
        chk("oor_d", data_out, 32'd0);
        chk("oor_err", 32'(sel_err), 32'd1);
        sel = 2'd0;
        tick();
        chk("oor_next_d", data_out, C_A);
        chk("oor_sticky", 32'(sel_err), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("oor_sticky2", 32'(sel_err), 32'd1);
        chk("oor_empty", 32'(out_valid), 32'd0);

        // Flush with both entries full and a word offered
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        tick();
        sel = 2'd1;
        tick();
        chk("fl_pre_rdy", 32'(in_ready), 32'd0);
        flush = 1'b1; sel = 2'd2;
        tick();
        chk("fl_v", 32'(out_valid), 32'd0);
        chk("fl_rdy", 32'(in_ready), 32'd1);
        chk("fl_err_kept", 32'(sel_err), 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("fl_nothing1", 32'(out_valid), 32'd0);
        tick();
        chk("fl_nothing2", 32'(out_valid), 32'd0);

        // Reset mid-operation with skid full
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        tick();
        sel = 2'd1;
        tick();
        chk("mr_pre_rdy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("mr_v", 32'(out_valid), 32'd0);
        chk("mr_d", data_out, 32'd0);
        chk("mr_err", 32'(sel_err), 32'd0);
        chk("mr_rdy", 32'(in_ready), 32'd1);
        rst = 1'b0; in_valid = 1'b0;
        tick();

        // Random sweep on the 8-bit, 5-input instance
        for (int n = 0; n < 1000; n++) begin
            s_in_valid  = 1'($urandom_range(0, 1));
            s_out_ready = 1'($urandom_range(0, 3) != 0);
            s_sel       = 3'($urandom_range(0, 7));
            s_data_in   = {8'($urandom), 32'($urandom)};
            chk("sw_out_valid", 32'(s_out_valid), 32'(q.size() != 0));
            chk("sw_in_ready", 32'(s_in_ready), 32'(q.size() < 2));
            if (s_out_valid && s_out_ready && q.size() != 0) begin
                exp_w = q.pop_front();
                chk("sw_data", 32'(s_data_out), 32'(exp_w));
            end
            if (s_in_valid && s_in_ready) begin
                exp_w = (s_sel < 3'd5) ? s_data_in[s_sel*8 +: 8] : 8'h00;
                q.push_back(exp_w);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
